dct_row_sched: RTL and testbench

Row scheduler for the 1-D 8-point distributed-arithmetic DCT stage. Collects eight signed 12-bit samples per row over a valid/ready stream, forms the even (sum) and odd (difference) butterfly operands, launches the eight per-coefficient DA engines (z0..z7) with a single start pulse, and captures their one-cycle result strobe at a fixed latency. Results are returned as an ordered z0..z7 stream. Input collection for the next row overlaps computation and drain of the current row.

---
 rtl/dct_pkg.sv | 35 +++
 rtl/dct_butterfly4.sv | 57 +++++
 rtl/dct_row_sched.sv | 164 ++++++++++++++++
 tb/tb_dct_row_sched.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared widths, engine FSM states and lane packing helpers for the DCT row scheduler
package dct_pkg;

    localparam int SAMPLE_W       = 12;
    localparam int ROW_LEN        = 8;
    localparam int LANE_CNT       = 4;
    localparam int DA_LAT_DEFAULT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } eng_state_t;

    // Lane k of a little-endian bus (lane 0 at the LSBs): row samples and da_result.
    function automatic logic [SAMPLE_W-1:0] lane_get(
        input logic [ROW_LEN*SAMPLE_W-1:0] bus,
        input int                          k
    );
        return bus[k*SAMPLE_W +: SAMPLE_W];
    endfunction

    // Operand buses are big-endian: lane 0 (s0/d0) occupies the MSBs.
    function automatic logic [LANE_CNT*SAMPLE_W-1:0] lane_put4(
        input logic [LANE_CNT*SAMPLE_W-1:0] bus,
        input int                           k,
        input logic [SAMPLE_W-1:0]          v
    );
        logic [LANE_CNT*SAMPLE_W-1:0] r;
        r = bus;
        r[(LANE_CNT-1-k)*SAMPLE_W +: SAMPLE_W] = v;
        return r;
    endfunction

endpackage

// File: rtl/dct_butterfly4.sv
// rtl/dct_butterfly4.sv - combinational 4-pair sum/difference butterfly with optional saturation
//
// Ports:
//   row   in  96  samples x0..x7, x0 at [11:0]
//   even  out 48  {s0,s1,s2,s3}, s_k = x_k + x_(7-k)
//   odd   out 48  {d0,d1,d2,d3}, d_k = x_k - x_(7-k)
// Build option: DCT_SCHED_SAT_EN defined -> results saturate to [-2048, 2047];
//               undefined -> results wrap to the low 12 bits.
module dct_butterfly4
    import dct_pkg::*;
(
    input  logic [ROW_LEN*SAMPLE_W-1:0]  row,
    output logic [LANE_CNT*SAMPLE_W-1:0] even,
    output logic [LANE_CNT*SAMPLE_W-1:0] odd
);

    logic [SAMPLE_W-1:0] a;
    logic [SAMPLE_W-1:0] b;

`ifdef DCT_SCHED_SAT_EN
    logic [SAMPLE_W:0] s13;
    logic [SAMPLE_W:0] d13;

    // The 13-bit result is exact; it overflowed 12 bits iff its top two bits differ.
    function automatic logic [SAMPLE_W-1:0] sat12(input logic [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1])
            return v[SAMPLE_W] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
        return v[SAMPLE_W-1:0];
    endfunction
`endif

    always_comb begin
        even = '0;
        odd  = '0;
        a    = '0;
        b    = '0;
`ifdef DCT_SCHED_SAT_EN
        s13  = '0;
        d13  = '0;
`endif
        for (int k = 0; k < LANE_CNT; k++) begin
            a = lane_get(row, k);
            b = lane_get(row, ROW_LEN - 1 - k);
`ifdef DCT_SCHED_SAT_EN
            s13  = {a[SAMPLE_W-1], a} + {b[SAMPLE_W-1], b};
            d13  = {a[SAMPLE_W-1], a} - {b[SAMPLE_W-1], b};
            even = lane_put4(even, k, sat12(s13));
            odd  = lane_put4(odd, k, sat12(d13));
`else
            // The low 12 bits of the 13-bit sum are exactly the 12-bit modular sum.
            even = lane_put4(even, k, a + b);
            odd  = lane_put4(odd, k, a - b);
`endif
        end
    end

endmodule

// File: rtl/dct_row_sched.sv
// rtl/dct_row_sched.sv - row scheduler: collects 8 samples, launches the DA engines, drains z0..z7
//
// Ports:
//   sys_clk, sys_rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready/in_data    sample stream x0..x7 (in_ready = !in_full)
//   da_start                     one-cycle launch pulse to all eight DA engines
//   da_even/da_odd               {s0..s3}/{d0..d3} operands, held from launch to next launch
//   da_result                    {z7..z0}, sampled DA_LAT cycles after the launch edge
//   out_valid/out_ready          coefficient stream handshake
//   out_data/out_index/out_last  coefficient, its index 0..7, last flag with index 7
//   busy                         engine FSM not IDLE
// Build option: DCT_SCHED_SAT_EN selects saturating butterfly outputs (see dct_butterfly4).
module dct_row_sched
    import dct_pkg::*;
#(
    parameter int DA_LAT = DA_LAT_DEFAULT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] in_data,
    output logic        da_start,
    output logic [47:0] da_even,
    output logic [47:0] da_odd,
    input  logic [95:0] da_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic [2:0]  out_index,
    output logic        out_last,
    output logic        busy
);

    localparam int WCNT_W = $clog2(DA_LAT + 1);

    logic [SAMPLE_W-1:0]          samples [ROW_LEN];
    logic [SAMPLE_W-1:0]          buffer  [ROW_LEN];
    logic [2:0]                   in_cnt;
    logic                         in_full;
    logic [WCNT_W-1:0]            wait_cnt;
    eng_state_t                   state;
    eng_state_t                   state_next;
    logic                         launch;
    logic                         capture;
    logic                         accept;
    logic                         out_hs;
    logic [2:0]                   index_next;
    logic [ROW_LEN*SAMPLE_W-1:0]  row_flat;
    logic [LANE_CNT*SAMPLE_W-1:0] bf_even;
    logic [LANE_CNT*SAMPLE_W-1:0] bf_odd;

    assign in_ready   = !in_full;
    assign accept     = in_valid && !in_full;
    assign out_hs     = out_valid && out_ready;
    assign index_next = out_index + 3'd1;
    assign busy       = (state != IDLE);

    always_comb begin
        row_flat = '0;
        for (int k = 0; k < ROW_LEN; k++)
            row_flat[k*SAMPLE_W +: SAMPLE_W] = samples[k];
    end

    dct_butterfly4 u_butterfly (
        .row  (row_flat),
        .even (bf_even),
        .odd  (bf_odd)
    );

    // Input side. Launch needs in_full and accept needs !in_full, so they never collide.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_cnt  <= '0;
            in_full <= 1'b0;
            for (int k = 0; k < ROW_LEN; k++)
                samples[k] <= '0;
        end else begin
            if (accept) begin
                samples[in_cnt] <= in_data;
                in_cnt          <= in_cnt + 3'd1;
                if (in_cnt == 3'd7)
                    in_full <= 1'b1;
            end
            if (launch)
                in_full <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        launch     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (in_full) begin
                    launch     = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // wait_cnt is 0 on the first WAIT cycle, so DA_LAT-1 marks the result edge.
                if (wait_cnt == WCNT_W'(DA_LAT - 1)) begin
                    capture    = 1'b1;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_hs && out_last)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            da_start  <= 1'b0;
            da_even   <= '0;
            da_odd    <= '0;
            wait_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            for (int k = 0; k < ROW_LEN; k++)
                buffer[k] <= '0;
        end else begin
            da_start <= launch;
            if (launch) begin
                da_even  <= bf_even;
                da_odd   <= bf_odd;
                wait_cnt <= '0;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + WCNT_W'(1);
            end

            if (capture) begin
                for (int k = 0; k < ROW_LEN; k++)
                    buffer[k] <= lane_get(da_result, k);
                out_valid <= 1'b1;
                out_index <= 3'd0;
                out_data  <= lane_get(da_result, 0);
                out_last  <= 1'b0;
            end else if (state == DRAIN && out_hs) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                end else begin
                    out_index <= index_next;
                    out_data  <= buffer[index_next];
                    out_last  <= (index_next == 3'd7);
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_row_sched.sv
// tb/tb_dct_row_sched.sv - scoreboard bench for dct_row_sched with a behavioural DA engine model
module tb_dct_row_sched;
    import dct_pkg::*;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_data;
    logic        da_start;
    logic [47:0] da_even;
    logic [47:0] da_odd;
    logic [95:0] da_result;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;

    always #5 sys_clk = ~sys_clk;

    dct_row_sched dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .da_start  (da_start),
        .da_even   (da_even),
        .da_odd    (da_odd),
        .da_result (da_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          last_hs  = -100;
    int          ready_mode = 0;
    bit          bp_done  = 0;
    int          bp_stalls = 0;
    logic [95:0] opq[$];
    int          acc7q[$];
    logic [15:0] outq[$];

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Reference butterfly written from the arithmetic definition on plain integers.
    function automatic logic [11:0] ref_reduce(input int v);
        int r;
        r = v;
`ifdef DCT_SCHED_SAT_EN
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
`endif
        return r[11:0];
    endfunction

    function automatic logic [95:0] ref_ops(input int x[8]);
        logic [47:0] e;
        logic [47:0] o;
        e = '0;
        o = '0;
        for (int k = 0; k < 4; k++) begin
            e = {e[35:0], ref_reduce(x[k] + x[7-k])};
            o = {o[35:0], ref_reduce(x[k] - x[7-k])};
        end
        return {e, o};
    endfunction

    // Engine model: z_(2j) = s_j + 2j, z_(2j+1) = d_j + 2j+1 (12-bit wrap).
    function automatic logic [95:0] z_model(input logic [95:0] ops);
        logic [95:0] z;
        logic [11:0] lane;
        z = '0;
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) lane = ops[95 - 12*(k/2) -: 12];
            else            lane = ops[47 - 12*(k/2) -: 12];
            z[12*k +: 12] = lane + 12'(k);
        end
        return z;
    endfunction

    task automatic send_row(input int x[8], input int max_gap);
        int t;
        int acc;
        logic [95:0] ops;
        logic [95:0] z;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge sys_clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = 12'(x[i]);
            t = 0;
            forever begin
                @(negedge sys_clk);
                if (in_ready) begin
                    acc = cyc + 1;
                    @(posedge sys_clk);
                    #1;
                    break;
                end
                t++;
                if (t > 2000) begin
                    fail_now("in_ready_timeout");
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
        ops = ref_ops(x);
        z   = z_model(ops);
        acc7q.push_back(acc);
        opq.push_back(ops);
        for (int k = 0; k < 8; k++)
            outq.push_back({(k == 7), 3'(k), z[12*k +: 12]});
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (outq.size() != 0 && t < 3000) begin
            @(posedge sys_clk);
            t++;
        end
        if (outq.size() != 0) fail_now("drain_timeout");
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"},  96'(in_ready),  96'd1);
        chk({tag, "_da_start"},  96'(da_start),  96'd0);
        chk({tag, "_out_valid"}, 96'(out_valid), 96'd0);
        chk({tag, "_out_last"},  96'(out_last),  96'd0);
        chk({tag, "_busy"},      96'(busy),      96'd0);
        chk({tag, "_da_even"},   96'(da_even),   96'd0);
        chk({tag, "_da_odd"},    96'(da_odd),    96'd0);
        chk({tag, "_out_data"},  96'(out_data),  96'd0);
        chk({tag, "_out_index"}, 96'(out_index), 96'd0);
    endtask

    // DA engine model: checks launch timing and operands, returns results in a one-cycle window.
    initial begin
        int          cd;
        int          a7;
        int          exp_l;
        bit          post;
        bit          drive_now;
        logic [95:0] ops;
        logic [95:0] cur_ops;
        cd = 0;
        post = 0;
        cur_ops = '0;
        da_result = '0;
        forever begin
            @(posedge sys_clk);
            cyc++;
            drive_now = 0;
            if (!sys_rst_n) begin
                cd = 0;
                post = 0;
                continue;
            end
            if (da_start) begin
                if (opq.size() == 0 || acc7q.size() == 0) begin
                    fail_now("unexpected_da_start");
                end else begin
                    ops = opq.pop_front();
                    a7  = acc7q.pop_front();
                    exp_l = (a7 + 1 > last_hs + 1) ? a7 + 1 : last_hs + 1;
                    chk("da_start_edge", 96'(cyc - 1), 96'(exp_l));
                    chk("da_even", 96'(da_even), 96'(ops[95:48]));
                    chk("da_odd",  96'(da_odd),  96'(ops[47:0]));
                    cur_ops = ops;
                    cd = 4;
                end
            end else if (cd > 0) begin
                cd--;
                drive_now = (cd == 0);
            end
            #1;
            if (drive_now) begin
                chk("operands_stable", {da_even, da_odd}, cur_ops);
                chk("valid_low_in_wait", 96'(out_valid), 96'd0);
                da_result = z_model(cur_ops);
                post = 1;
            end else begin
                da_result = {$urandom, $urandom, $urandom};
                if (post) begin
                    chk("first_out_valid", 96'(out_valid), 96'd1);
                    chk("first_out_index", 96'(out_index), 96'd0);
                    post = 0;
                end
            end
        end
    end

    // Output monitor: pops the scoreboard on every handshake and checks stall hold.
    initial begin
        bit          prev_stall;
        logic [15:0] prev_word;
        logic [15:0] e;
        prev_stall = 0;
        prev_word  = '0;
        forever begin
            @(negedge sys_clk);
            if (!sys_rst_n) begin
                prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                chk("stall_valid", 96'(out_valid), 96'd1);
                chk("stall_hold", 96'({out_last, out_index, out_data}), 96'(prev_word));
            end
            if (out_valid && !out_ready && out_index == 3'd3 && ready_mode == 2)
                bp_stalls++;
            if (out_valid && out_ready) begin
                if (outq.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = outq.pop_front();
                    chk("out_word", 96'({out_last, out_index, out_data}), 96'(e));
                end
                if (out_last) last_hs = cyc + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {out_last, out_index, out_data};
        end
    end

    // Downstream ready driver.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge sys_clk);
            #1;
            case (ready_mode)
                1: out_ready = ($urandom_range(0, 3) != 0);
                2: begin
                    if (!bp_done && out_valid && out_index == 3'd3) begin
                        out_ready = 1'b0;
                        repeat (5) @(posedge sys_clk);
                        #1;
                        out_ready = 1'b1;
                        bp_done = 1;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        int x[8];
        sys_rst_n = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset_values("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        x = '{10, 10, 10, 10, 10, 10, 10, 10};
        send_row(x, 0);
        wait_drain();
        chk("tens_even", 96'(da_even), 96'h014014014014);
        chk("tens_odd",  96'(da_odd),  96'd0);

        x = '{0, 1, 2, 3, 4, 5, 6, 7};
        send_row(x, 1);
        wait_drain();
        chk("ramp_even", 96'(da_even), 96'h007007007007);
        chk("ramp_odd",  96'(da_odd),  96'hFF9FFBFFDFFF);

        x = '{2047, 0, 0, 0, 0, 0, 0, 1};
        send_row(x, 0);
        wait_drain();
`ifdef DCT_SCHED_SAT_EN
        chk("s0_boundary", 96'(da_even[47:36]), 96'h7FF);
`else
        chk("s0_boundary", 96'(da_even[47:36]), 96'h800);
`endif
        chk("d0_boundary", 96'(da_odd[47:36]), 96'd2046);

        ready_mode = 2;
        for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
        send_row(x, 0);
        wait_drain();
        chk("bp_stall_cycles", 96'(bp_stalls), 96'd5);
        ready_mode = 0;

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
            send_row(x, 0);
        end
        wait_drain();

        ready_mode = 1;
        for (int r = 0; r < 16; r++) begin
            for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
            send_row(x, 2);
        end
        wait_drain();
        ready_mode = 0;

        for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
        send_row(x, 0);
        repeat (3) @(posedge sys_clk);
        #2;
        sys_rst_n = 1'b0;
        #1;
        check_reset_values("midwait_reset");
        opq.delete();
        acc7q.delete();
        outq.delete();
        last_hs = -100;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;

        for (int i = 0; i < 8; i++) x[i] = int'($urandom_range(0, 4095)) - 2048;
        send_row(x, 1);
        wait_drain();
        chk("opq_empty", 96'(opq.size()), 96'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
